// File: rtl/qsys_pulse_pio.sv
`default_nettype none
// ============================================================================
//  Module   : qsys_pulse_pio
//  Purpose  : Avalon-MM parallel output port; each channel runs as a plain
//             level output or as a retriggerable fixed-length pulse.
//  Revision : 1.0  initial release
// ============================================================================
module qsys_pulse_pio #(
    parameter int               WIDTH       = 8,
    parameter int               CNT_W       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             busy
);

    localparam logic [2:0]       c_addr_data   = 3'd0;
    localparam logic [2:0]       c_addr_mode   = 3'd1;
    localparam logic [2:0]       c_addr_plen   = 3'd2;
    localparam logic [2:0]       c_addr_status = 3'd3;
    localparam logic [2:0]       c_addr_set    = 3'd4;
    localparam logic [2:0]       c_addr_clr    = 3'd5;
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_mode;
    logic [CNT_W-1:0] r_plen;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic             r_busy;

    logic [WIDTH-1:0] w_out_nxt;
    logic [WIDTH-1:0] w_mode_nxt;
    logic [CNT_W-1:0] w_plen_nxt;
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] w_status;
    logic [WIDTH-1:0] w_status_nxt;
    logic [CNT_W-1:0] w_plen_eff;
    logic [WIDTH-1:0] w_wd;
    logic             w_wr;
    logic             w_wr_data;
    logic             w_wr_mode;
    logic             w_wr_plen;
    logic             w_wr_set;
    logic             w_wr_clr;
    logic             w_unused_ok;

    assign w_wr        = chipselect & ~write_n;
    assign w_wr_data   = w_wr & (address == c_addr_data);
    assign w_wr_mode   = w_wr & (address == c_addr_mode);
    assign w_wr_plen   = w_wr & (address == c_addr_plen);
    assign w_wr_set    = w_wr & (address == c_addr_set);
    assign w_wr_clr    = w_wr & (address == c_addr_clr);
    assign w_wd        = writedata[WIDTH-1:0];
    assign w_unused_ok = &{1'b0, writedata};

    // A programmed length of zero still yields a one-cycle pulse.
    assign w_plen_eff  = (r_plen == '0) ? c_cnt_one : r_plen;

    always_comb begin
        w_mode_nxt   = w_wr_mode ? w_wd : r_mode;
        w_plen_nxt   = w_wr_plen ? writedata[CNT_W-1:0] : r_plen;
        w_out_nxt    = r_out;
        w_status     = '0;
        w_status_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (!r_mode[i]) begin
                w_cnt_nxt[i] = '0;
                if (w_wr_data) begin
                    w_out_nxt[i] = w_wd[i];
                end else if (w_wr_set && w_wd[i]) begin
                    w_out_nxt[i] = 1'b1;
                end else if (w_wr_clr && w_wd[i]) begin
                    w_out_nxt[i] = 1'b0;
                end
            end else if ((w_wr_data || w_wr_set) && w_wd[i]) begin
                // Host trigger wins over an expiry landing on the same edge.
                w_out_nxt[i] = 1'b1;
                w_cnt_nxt[i] = w_plen_eff;
            end else if ((w_wr_data && !w_wd[i]) || (w_wr_clr && w_wd[i])) begin
                w_out_nxt[i] = 1'b0;
                w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] > c_cnt_one) begin
                w_cnt_nxt[i] = r_cnt[i] - c_cnt_one;
            end else if (r_cnt[i] == c_cnt_one) begin
                w_out_nxt[i] = 1'b0;
                w_cnt_nxt[i] = '0;
            end
            // Dropping back to level mode freezes the pin at its present value.
            if (w_wr_mode && r_mode[i] && !w_wd[i]) begin
                w_cnt_nxt[i] = '0;
                w_out_nxt[i] = r_out[i];
            end
            w_status[i]     = (r_cnt[i] != '0);
            w_status_nxt[i] = (w_cnt_nxt[i] != '0);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            c_addr_data:   readdata[WIDTH-1:0] = r_out;
            c_addr_mode:   readdata[WIDTH-1:0] = r_mode;
            c_addr_plen:   readdata[CNT_W-1:0] = r_plen;
            c_addr_status: readdata[WIDTH-1:0] = w_status;
            default:       readdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out  <= RESET_VALUE;
            r_mode <= '0;
            r_plen <= c_cnt_one;
            r_busy <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_out  <= w_out_nxt;
            r_mode <= w_mode_nxt;
            r_plen <= w_plen_nxt;
            r_busy <= |w_status_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign out_port = r_out;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_qsys_pulse_pio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qsys_pulse_pio
//  Purpose  : Directed scoreboard bench for qsys_pulse_pio (WIDTH=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_qsys_pulse_pio;

    localparam int         W    = 8;
    localparam logic [7:0] RSTV = 8'h5A;
    localparam int         K_OUT  = 0;
    localparam int         K_BUSY = 1;
    localparam int         K_RD   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [W-1:0]  out_port;
    logic          busy;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    qsys_pulse_pio #(
        .WIDTH       (W),
        .CNT_W       (16),
        .RESET_VALUE (RSTV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every negedge, compare each expectation due in this cycle.
    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                act = '0;
                case (sb[i].kind)
                    K_OUT:   act[W-1:0] = out_port;
                    K_BUSY:  act[0]     = busy;
                    default: act        = readdata;
                endcase
                checks++;
                if (act !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d actual=%h required=%h", sb[i].name, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s cyc=%0d never sampled", sb[i].name, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    task automatic push(input int c, input int k, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns just after the edge that accepted the write.
    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] v, input string n);
        address = a;
        push(cyc, K_RD, v, n);
        step(1);
    endtask

    // Expect ch0 high for hi cycles starting at c0, then low with busy clear.
    task automatic push_pulse(input int c0, input int hi, input string n);
        for (int j = 0; j < hi; j++) begin
            push(c0 + j, K_OUT, 32'h27, n);
            push(c0 + j, K_BUSY, 32'h1, {n, "_busy"});
        end
        push(c0 + hi, K_OUT, 32'h26, {n, "_end"});
        push(c0 + hi, K_BUSY, 32'h0, {n, "_end_busy"});
    endtask

    initial begin
        int c;
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        step(3);
        push(cyc, K_OUT, 32'h5A, "rst_out");
        push(cyc, K_BUSY, 32'h0, "rst_busy");
        step(1);
        reset = 1'b0;

        rd(3'd0, 32'h5A, "rst_data");
        rd(3'd1, 32'h0,  "rst_mode");
        rd(3'd2, 32'h1,  "rst_plen");
        rd(3'd3, 32'h0,  "rst_status");
        for (int a = 4; a < 8; a++) begin
            rd(3'(a), 32'h0, "rst_hi_addr");
        end

        // Level mode.
        push(cyc, K_OUT, 32'h5A, "lvl_before");
        do_write(3'd0, 32'hFFFF_FFA5);
        push(cyc, K_OUT, 32'hA5, "lvl_data");
        do_write(3'd4, 32'h02);
        push(cyc, K_OUT, 32'hA7, "lvl_set");
        do_write(3'd5, 32'h80);
        push(cyc, K_OUT, 32'h27, "lvl_clr");
        rd(3'd0, 32'h27, "lvl_rd_data");
        rd(3'd4, 32'h0,  "rd_outset");
        do_write(3'd5, 32'h01);
        push(cyc, K_OUT, 32'h26, "lvl_clr0");

        // Basic pulse, STATUS tracked alongside.
        do_write(3'd1, 32'h01);
        do_write(3'd2, 32'h0005);
        rd(3'd1, 32'h01, "rd_mode");
        rd(3'd2, 32'h05, "rd_plen");
        push(cyc, K_OUT, 32'h26, "mode_sw_keep");
        do_write(3'd0, 32'h27);
        c = cyc;
        push_pulse(c, 5, "pulse5");
        address = 3'd3;
        for (int j = 0; j < 5; j++) push(c + j, K_RD, 32'h1, "pulse5_status");
        push(c + 5, K_RD, 32'h0, "pulse5_status_end");
        step(7);

        // Retrigger: OUTSET lands on the edge that opens the third high cycle.
        do_write(3'd2, 32'h4);
        do_write(3'd0, 32'h27);
        c = cyc;
        push_pulse(c, 6, "retrig");
        step(1);
        do_write(3'd4, 32'h01);
        step(5);

        // Retrigger on the expiry edge: stays high, no gap.
        do_write(3'd0, 32'h27);
        c = cyc;
        push_pulse(c, 8, "retrig_expiry");
        step(3);
        do_write(3'd4, 32'h01);
        step(5);

        // Rewriting PULSE_LEN leaves the running count alone.
        do_write(3'd2, 32'h3);
        do_write(3'd0, 32'h27);
        c = cyc;
        push_pulse(c, 3, "plen_rewrite_run");
        step(1);
        do_write(3'd2, 32'h8);
        step(2);
        do_write(3'd0, 32'h27);
        c = cyc;
        push_pulse(c, 8, "plen_rewrite_new");
        step(9);

        // Cancel via OUTCLEAR.
        do_write(3'd2, 32'd10);
        do_write(3'd0, 32'h27);
        c = cyc;
        push_pulse(c, 3, "cancel");
        push(c + 4, K_OUT, 32'h26, "cancel_stay");
        step(2);
        do_write(3'd5, 32'h01);
        step(2);

        // Cancel via MODE 1->0: output frozen high.
        do_write(3'd0, 32'h27);
        c = cyc;
        for (int j = 0; j < 3; j++) push(c + j, K_OUT, 32'h27, "mode_off_hi");
        for (int j = 3; j < 6; j++) begin
            push(c + j, K_OUT, 32'h27, "mode_off_hold");
            push(c + j, K_BUSY, 32'h0, "mode_off_busy");
        end
        step(2);
        do_write(3'd1, 32'h00);
        rd(3'd3, 32'h0, "mode_off_status");
        step(2);
        do_write(3'd5, 32'h01);
        push(cyc, K_OUT, 32'h26, "mode_off_clr");
        do_write(3'd1, 32'h01);

        // Zero length gives a single-cycle pulse.
        do_write(3'd2, 32'h0);
        rd(3'd2, 32'h0, "rd_plen0");
        do_write(3'd0, 32'h27);
        c = cyc;
        push_pulse(c, 1, "plen0");
        step(2);

        // Reset mid-pulse, with a competing DATA write on the same edge.
        do_write(3'd2, 32'd10);
        do_write(3'd0, 32'h27);
        c = cyc;
        push(c, K_OUT, 32'h27, "pre_rst_hi");
        push(c + 1, K_BUSY, 32'h1, "pre_rst_busy");
        step(1);
        reset      = 1'b1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd0;
        writedata  = 32'hFF;
        step(1);
        reset      = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        push(cyc, K_OUT, 32'h5A, "midrst_out");
        push(cyc, K_BUSY, 32'h0, "midrst_busy");
        push(cyc + 1, K_OUT, 32'h5A, "midrst_out_hold");
        step(1);
        rd(3'd1, 32'h0, "midrst_mode");
        rd(3'd2, 32'h1, "midrst_plen");
        rd(3'd3, 32'h0, "midrst_status");

        step(2);
        if (sb.size() != 0) begin
            failures += sb.size();
            $display("FAIL scoreboard_leftover count=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qsys_pulse_pio.md
QSYS_PULSE_PIO -- requirements
Module: qsys_pulse_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of output channels (legal 1..32).
REQ-002 SHALL have parameter CNT_W, default 16, pulse-length counter width (legal 2..32).
REQ-003 SHALL have parameter RESET_VALUE, default 0, WIDTH-bit reset value of out_port.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port address  input  3  Avalon-MM word address.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  active-low write strobe.
REQ-009 SHALL have port writedata  input  32  write data; bits above the used field ignored.
REQ-010 SHALL have port readdata  output  32  read data, zero-extended.
REQ-011 SHALL have port out_port  output  WIDTH  channel outputs, registered.
REQ-012 SHALL have port busy  output  1  OR of all channel pulse-active flags, registered.

Function
REQ-013 SHALL accept a write on any rising edge with chipselect=1 and write_n=0; no wait states.
REQ-014 SHALL drive readdata combinationally from address (read latency 0), independent of chipselect.
REQ-015 SHALL implement map: 0 DATA (RW), 1 MODE (RW), 2 PULSE_LEN (RW), 3 STATUS (RO), 4 OUTSET (WO), 5 OUTCLEAR (WO), 6-7 reserved (read 0, writes ignored).
REQ-016 SHALL read DATA as current out_port; SHALL read OUTSET/OUTCLEAR as 0; writes to STATUS ignored.
REQ-017 SHALL per channel i operate level mode when MODE[i]=0, pulse mode when MODE[i]=1.
REQ-018 SHALL, level mode, update out_port[i] on the edge after a DATA write to writedata[i]; OUTSET bit=1 sets, OUTCLEAR bit=1 clears, 0 bits leave unchanged.
REQ-019 SHALL, pulse mode, treat a 1 written via DATA or OUTSET as trigger: out_port[i]<=1, cnt[i]<=PULSE_LEN (0 treated as 1).
REQ-020 SHALL, each cycle with cnt[i]>1, decrement cnt[i]; at cnt[i]=1 drive out_port[i]<=0, cnt[i]<=0; out_port[i] high exactly PULSE_LEN cycles.
REQ-021 SHALL, pulse mode, treat DATA bit 0 or OUTCLEAR bit 1 as cancel: out_port[i]<=0, cnt[i]<=0 on next edge.
REQ-022 SHALL restart cnt[i] at PULSE_LEN on retrigger while active (no extra low cycle).
REQ-023 SHALL give host write priority over counter expiry in the same cycle.
REQ-024 SHALL, on MODE[i] write 1->0, clear cnt[i] and hold out_port[i] at its current value; 0->1 leaves out_port[i] unchanged.
REQ-025 SHALL not alter running counters when PULSE_LEN is rewritten; new value applies to later triggers.
REQ-026 SHALL read STATUS[i]=1 iff cnt[i]!=0; busy SHALL equal OR of STATUS.
REQ-027 SHALL store PULSE_LEN as writedata[CNT_W-1:0]; MODE and DATA use writedata[WIDTH-1:0].

Reset
REQ-028 SHALL, on edge with reset=1, set out_port=RESET_VALUE, MODE=0, PULSE_LEN=1, all cnt=0, busy=0; reset overrides same-cycle writes.
REQ-029 SHALL abort active pulses on reset mid-pulse; outputs return to RESET_VALUE next edge.

Verification
REQ-030 Reset, read all addresses -> DATA=RESET_VALUE, MODE=0, PULSE_LEN=1, STATUS=0, 4-7 read 0.
REQ-031 Level: DATA=0xA5, OUTSET=0x02, OUTCLEAR=0x80 -> out_port 0xA5, 0xA7, 0x27, each one edge after write.
REQ-032 Pulse: MODE=0x01, PULSE_LEN=5, DATA=0x01 -> out_port[0] high exactly 5 cycles, STATUS/busy high same 5 cycles, then 0.
REQ-033 Retrigger: PULSE_LEN=4, trigger, OUTSET=0x01 at third high cycle -> total 6 high cycles; trigger coinciding with expiry keeps output high.
REQ-034 Cancel/mode: PULSE_LEN=10, trigger, OUTCLEAR=0x01 after 3 cycles -> low next edge, busy=0; repeat with MODE=0 write -> output held 1, busy=0.
REQ-035 PULSE_LEN=0 trigger -> 1-cycle pulse; reset asserted mid-pulse -> out_port=RESET_VALUE, busy=0 next edge.
